// File: rtl/sdram_device_model.sv
// Device end of the 32-bit single-access SDRAM interface: command decode, per-bank
// row/tRCD tracking, byte-masked storage, CAS-latency read pipe and sticky error report.
module sdram_device_model #(
  parameter int MEM_AW   = 12,
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 8,
  parameter int TRCD_CYC = 1,
  parameter int TRFC_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_cke,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [3:0]  sd_dqm,
  input  logic [31:0] sd_data_in,
  output logic [31:0] sd_data_out,
  output logic [3:0]  sd_data_oe,
  output logic        mode_loaded,
  output logic [15:0] refresh_count,
  output logic        err,
  output logic [3:0]  err_code
);

  localparam int FA_W = 2 + ROW_BITS + COL_BITS;
  localparam logic [3:0] TRCD_V = 4'(TRCD_CYC);
  localparam logic [3:0] TRFC_V = 4'(TRFC_CYC);

  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  logic [31:0]         mem_q [2**MEM_AW];
  logic [3:0]          open_q;
  logic [ROW_BITS-1:0] row_q [4];
  logic [3:0]          trcd_q [4];
  logic [3:0]          trfc_q;
  logic [1:0]          cl_q;
  logic [1:0]          pipe_v_q;
  logic [1:0][3:0]     pipe_be_q;
  logic [1:0][31:0]    pipe_data_q;
  logic [31:0]         data_out_q;
  logic [3:0]          oe_q;
  logic                mode_loaded_q;
  logic [15:0]         refresh_q;
  logic                err_q;
  logic [3:0]          err_code_q;

  cmd_e              cmd_s;
  logic [FA_W-1:0]   full_addr_s;
  logic [MEM_AW-1:0] idx_s;
  logic [31:0]       rd_word_s;
  logic [3:0]        code_s;
  logic              do_act_s, do_rd_s, do_wr_s, do_pre_s, do_ref_s, do_lmr_s;
  logic              wr_conflict_s;
  logic              unused_ok_s;

  assign cmd_s       = cmd_e'({sd_cs, sd_ras, sd_cas, sd_we});
  assign full_addr_s = {sd_ba, row_q[sd_ba], sd_addr[COL_BITS-1:0]};
  assign idx_s       = full_addr_s[MEM_AW-1:0];
  assign rd_word_s   = mem_q[idx_s];
  assign unused_ok_s = ^{sd_addr, full_addr_s};

  // Command decode with legality checks; at most one error code per edge.
  always_comb begin
    code_s   = 4'd0;
    do_act_s = 1'b0;
    do_rd_s  = 1'b0;
    do_wr_s  = 1'b0;
    do_pre_s = 1'b0;
    do_ref_s = 1'b0;
    do_lmr_s = 1'b0;
    if (sd_cs || cmd_s == CMD_NOP) begin
      code_s = 4'd0;
    end else if (trfc_q != 4'd0) begin
      code_s = 4'd6;
    end else begin
      case (cmd_s)
        CMD_ACT: begin
          if (open_q[sd_ba]) code_s = 4'd1;
          else               do_act_s = 1'b1;
        end
        CMD_RD, CMD_WR: begin
          if (!mode_loaded_q)              code_s = 4'd4;
          else if (!open_q[sd_ba])         code_s = 4'd2;
          else if (trcd_q[sd_ba] != 4'd0)  code_s = 4'd3;
          else if (cmd_s == CMD_RD)        do_rd_s = 1'b1;
          else                             do_wr_s = 1'b1;
        end
        CMD_PRE: do_pre_s = 1'b1;
        CMD_REF: begin
          if (|open_q) code_s = 4'd5;
          else         do_ref_s = 1'b1;
        end
        CMD_LMR: begin
          if (|open_q) begin
            code_s = 4'd5;
          end else if ((sd_addr[6:4] != 3'd2 && sd_addr[6:4] != 3'd3) || sd_addr[2:0] != 3'd0) begin
            code_s = 4'd7;
          end else begin
            do_lmr_s = 1'b1;
          end
        end
        default: code_s = 4'd0;
      endcase
    end
    // A write while read data is about to take the bus collides with that data.
    wr_conflict_s = !sd_cs && cmd_s == CMD_WR && pipe_v_q[1];
    if (wr_conflict_s && code_s == 4'd0) begin
      code_s = 4'd8;
    end else begin
      code_s = code_s;
    end
  end

  // Byte-masked storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && sd_cke && do_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (!sd_dqm[b]) mem_q[idx_s][8*b +: 8] <= sd_data_in[8*b +: 8];
      end
    end
  end

  // Bank state, timers, mode, read pipeline and error report.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      open_q        <= 4'd0;
      for (int b = 0; b < 4; b++) trcd_q[b] <= 4'd0;
      trfc_q        <= 4'd0;
      cl_q          <= 2'd3;
      pipe_v_q      <= 2'd0;
      pipe_be_q     <= '0;
      pipe_data_q   <= '0;
      data_out_q    <= 32'd0;
      oe_q          <= 4'd0;
      mode_loaded_q <= 1'b0;
      refresh_q     <= 16'd0;
      err_q         <= 1'b0;
      err_code_q    <= 4'd0;
    end else if (sd_cke) begin
      for (int b = 0; b < 4; b++) begin
        if (do_act_s && sd_ba == 2'(b)) trcd_q[b] <= TRCD_V;
        else if (trcd_q[b] != 4'd0)     trcd_q[b] <= trcd_q[b] - 4'd1;
      end
      if (do_ref_s)              trfc_q <= TRFC_V;
      else if (trfc_q != 4'd0)   trfc_q <= trfc_q - 4'd1;

      if (do_act_s) begin
        open_q[sd_ba] <= 1'b1;
        row_q[sd_ba]  <= sd_addr[ROW_BITS-1:0];
      end else if (do_pre_s) begin
        if (sd_addr[10]) open_q <= 4'd0;
        else             open_q[sd_ba] <= 1'b0;
      end else if ((do_rd_s || do_wr_s) && sd_addr[10]) begin
        open_q[sd_ba] <= 1'b0;
      end

      if (do_ref_s) refresh_q <= refresh_q + 16'd1;
      if (do_lmr_s) begin
        cl_q          <= sd_addr[5:4];
        mode_loaded_q <= 1'b1;
      end

      // Stage 1 feeds stage 0, stage 0 feeds the bus; new reads enter at CL-2.
      data_out_q     <= pipe_v_q[0] ? pipe_data_q[0] : 32'd0;
      oe_q           <= pipe_v_q[0] ? pipe_be_q[0] : 4'd0;
      pipe_v_q[0]    <= pipe_v_q[1] & ~wr_conflict_s;
      pipe_be_q[0]   <= pipe_be_q[1];
      pipe_data_q[0] <= pipe_data_q[1];
      pipe_v_q[1]    <= 1'b0;
      if (do_rd_s) begin
        if (cl_q == 2'd2) begin
          pipe_v_q[0]    <= 1'b1;
          pipe_be_q[0]   <= ~sd_dqm;
          pipe_data_q[0] <= rd_word_s;
        end else begin
          pipe_v_q[1]    <= 1'b1;
          pipe_be_q[1]   <= ~sd_dqm;
          pipe_data_q[1] <= rd_word_s;
        end
      end

      if (!err_q && code_s != 4'd0) begin
        err_q      <= 1'b1;
        err_code_q <= code_s;
      end
    end
  end

  assign sd_data_out   = data_out_q;
  assign sd_data_oe    = oe_q;
  assign mode_loaded   = mode_loaded_q;
  assign refresh_count = refresh_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model (built with TRCD_CYC=2): read/write data path,
// CAS latencies, byte masks, error codes, refresh counting and reset behaviour.
module tb_sdram_device_model;

  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sd_cke;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [3:0]  sd_dqm;
  logic [31:0] sd_data_in;
  logic [31:0] sd_data_out;
  logic [3:0]  sd_data_oe;
  logic        mode_loaded;
  logic [15:0] refresh_count;
  logic        err;
  logic [3:0]  err_code;

  int passed = 0;
  int total  = 0;

  sdram_device_model #(.TRCD_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .sd_cke(sd_cke),
    .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
    .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_data_in(sd_data_in),
    .sd_data_out(sd_data_out), .sd_data_oe(sd_data_oe), .mode_loaded(mode_loaded),
    .refresh_count(refresh_count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one command for one edge, then sit 1ns past that edge.
  task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                      input logic [3:0] dqm, input logic [31:0] din);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = addr; sd_dqm = dqm; sd_data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 2'd0, 13'd0, 4'd0, 32'd0);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    nop(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; sd_cke = 1'b1;
    {sd_cs, sd_ras, sd_cas, sd_we} = 4'b1111;
    sd_ba = 2'd0; sd_addr = 13'd0; sd_dqm = 4'd0; sd_data_in = 32'd0;
    do_reset();
    check("rst_oe", {28'd0, sd_data_oe}, 32'd0);
    check("rst_data", sd_data_out, 32'd0);
    check("rst_mode", {31'd0, mode_loaded}, 32'd0);
    check("rst_refcnt", {16'd0, refresh_count}, 32'd0);
    check("rst_err", {27'd0, err, err_code}, 32'd0);

    // CL=2 write/read
    step(C_LMR, 2'd0, 13'h220, 4'd0, 32'd0);
    check("lmr_mode", {31'd0, mode_loaded}, 32'd1);
    step(C_ACT, 2'd1, 13'h155, 4'd0, 32'd0);
    nop(2);
    step(C_WR, 2'd1, 13'h012, 4'd0, 32'hDEADBEEF);
    step(C_RD, 2'd1, 13'h012, 4'd0, 32'd0);
    check("cl2_oe_n", {28'd0, sd_data_oe}, 32'd0);
    nop(1);
    check("cl2_oe", {28'd0, sd_data_oe}, 32'hF);
    check("cl2_data", sd_data_out, 32'hDEADBEEF);
    nop(1);
    check("cl2_oe_after", {28'd0, sd_data_oe}, 32'd0);
    check("cl2_err", {27'd0, err, err_code}, 32'd0);

    // CL=3 with masked write
    step(C_PRE, 2'd0, 13'h400, 4'd0, 32'd0);
    step(C_LMR, 2'd0, 13'h230, 4'd0, 32'd0);
    step(C_ACT, 2'd0, 13'h002, 4'd0, 32'd0);
    nop(2);
    step(C_WR, 2'd0, 13'h020, 4'd0, 32'hAAAAAAAA);
    step(C_WR, 2'd0, 13'h020, 4'b0011, 32'h11223344);
    step(C_RD, 2'd0, 13'h020, 4'd0, 32'd0);
    nop(1);
    check("cl3_oe_n1", {28'd0, sd_data_oe}, 32'd0);
    nop(1);
    check("cl3_oe", {28'd0, sd_data_oe}, 32'hF);
    check("cl3_merge", sd_data_out, 32'h1122AAAA);

    // read byte mask
    step(C_RD, 2'd0, 13'h020, 4'b1100, 32'd0);
    nop(2);
    check("dqm_oe", {28'd0, sd_data_oe}, 32'h3);

    // back-to-back reads
    step(C_WR, 2'd0, 13'h000, 4'd0, 32'h0000A0A0);
    step(C_WR, 2'd0, 13'h001, 4'd0, 32'h0000B1B1);
    step(C_RD, 2'd0, 13'h000, 4'd0, 32'd0);
    step(C_RD, 2'd0, 13'h001, 4'd0, 32'd0);
    nop(1);
    check("b2b_d0", sd_data_out, 32'h0000A0A0);
    check("b2b_oe0", {28'd0, sd_data_oe}, 32'hF);
    nop(1);
    check("b2b_d1", sd_data_out, 32'h0000B1B1);
    nop(1);
    check("b2b_oe_end", {28'd0, sd_data_oe}, 32'd0);
    check("b2b_err", {27'd0, err, err_code}, 32'd0);

    // write colliding with pending read data
    step(C_RD, 2'd0, 13'h000, 4'd0, 32'd0);
    step(C_WR, 2'd0, 13'h002, 4'd0, 32'h12345678);
    nop(1);
    check("e8_oe", {28'd0, sd_data_oe}, 32'd0);
    check("e8_code", {27'd0, err, err_code}, {27'd0, 1'b1, 4'd8});

    // read to a closed bank
    do_reset();
    step(C_LMR, 2'd0, 13'h220, 4'd0, 32'd0);
    step(C_RD, 2'd2, 13'h010, 4'd0, 32'd0);
    nop(1);
    check("e2_code", {27'd0, err, err_code}, {27'd0, 1'b1, 4'd2});
    check("e2_oe", {28'd0, sd_data_oe}, 32'd0);

    // tRCD violation
    do_reset();
    step(C_LMR, 2'd0, 13'h220, 4'd0, 32'd0);
    step(C_ACT, 2'd0, 13'h000, 4'd0, 32'd0);
    step(C_RD, 2'd0, 13'h000, 4'd0, 32'd0);
    check("e3_code", {27'd0, err, err_code}, {27'd0, 1'b1, 4'd3});

    // refresh with a bank open
    do_reset();
    step(C_ACT, 2'd3, 13'h000, 4'd0, 32'd0);
    step(C_REF, 2'd0, 13'h000, 4'd0, 32'd0);
    check("e5_code", {27'd0, err, err_code}, {27'd0, 1'b1, 4'd5});
    check("e5_refcnt", {16'd0, refresh_count}, 32'd0);

    // three legal refreshes, then a command inside tRFC
    do_reset();
    step(C_REF, 2'd0, 13'h000, 4'd0, 32'd0);
    nop(2);
    step(C_REF, 2'd0, 13'h000, 4'd0, 32'd0);
    nop(2);
    step(C_REF, 2'd0, 13'h000, 4'd0, 32'd0);
    check("ref_cnt3", {16'd0, refresh_count}, 32'd3);
    check("ref_noerr", {27'd0, err, err_code}, 32'd0);
    step(C_ACT, 2'd0, 13'h000, 4'd0, 32'd0);
    check("e6_code", {27'd0, err, err_code}, {27'd0, 1'b1, 4'd6});

    // reset while a read is in flight
    do_reset();
    step(C_LMR, 2'd0, 13'h230, 4'd0, 32'd0);
    step(C_ACT, 2'd0, 13'h002, 4'd0, 32'd0);
    nop(2);
    step(C_RD, 2'd0, 13'h020, 4'd0, 32'd0);
    reset_n = 1'b0;
    nop(1);
    check("rstrd_mode", {31'd0, mode_loaded}, 32'd0);
    check("rstrd_oe0", {28'd0, sd_data_oe}, 32'd0);
    reset_n = 1'b1;
    nop(1);
    check("rstrd_oe1", {28'd0, sd_data_oe}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_device_model.md
Name: sdram_device_model

Overview:
- Cycle-accurate, synthesizable SDRAM responder: the device end of the 32-bit single-access SDRAM command interface that our 32 MHz controller drives.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and timing, stores data in an internal array, and returns read data after the programmed CAS latency.
- Used in Verilator and FPGA loopback benches in place of the physical chip; flags protocol violations through a sticky error report.

Parameters:
- MEM_AW, 12, log2 of stored 32-bit words; storage index = low MEM_AW bits of {ba,row,col}
- ROW_BITS, 11, row address bits taken from sd_addr at ACTIVE
- COL_BITS, 8, column bits taken from sd_addr at READ/WRITE
- TRCD_CYC, 1, minimum cycles from ACTIVE to READ/WRITE on the same bank
- TRFC_CYC, 2, cycles after AUTO_REFRESH during which only NOP/INHIBIT are legal

Ports:
- clk  in  1  device clock; the bench connects the controller's sd_clk
- reset_n  in  1  synchronous, active-low reset
- sd_cke  in  1  clock enable; 0 freezes all state
- sd_cs  in  1  chip select, active low
- sd_ras  in  1  row strobe, active low
- sd_cas  in  1  column strobe, active low
- sd_we  in  1  write enable, active low
- sd_ba  in  2  bank address
- sd_addr  in  13  multiplexed address; A10 = precharge-all / auto-precharge
- sd_dqm  in  4  byte masks, active high; bit3 = bits 31:24
- sd_data_in  in  32  write data from the controller
- sd_data_out  out  32  read data
- sd_data_oe  out  4  per-byte drive enable for sd_data_out
- mode_loaded  out  1  a valid LOAD_MODE has been accepted
- refresh_count  out  16  AUTO_REFRESH commands accepted; wraps
- err  out  1  sticky protocol error
- err_code  out  4  code of the first error

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All banks closed; tRCD/tRFC counters 0; read pipeline empty.
  - CL register = 3; mode_loaded=0, sd_data_oe=0, sd_data_out=0, refresh_count=0, err=0, err_code=0.
  - Memory contents are not cleared.
  - Reset mid-read drops pending data; oe=0 on the next cycle.
- Command {cs,ras,cas,we} is sampled each edge while sd_cke=1. INHIBIT (1xxx), NOP 0111 and BURST_TERMINATE 0110 cause no action.
- ACTIVE 0011:
  - Bank ba must be closed, else error 1.
  - Records row = sd_addr[ROW_BITS-1:0], opens the bank and loads tRCD counter[ba] = TRCD_CYC.
- READ 0101 / WRITE 0100 checks, in priority order:
  - Requires mode_loaded (else error 4).
  - Bank open (else error 2).
  - tRCD counter[ba]=0 (else error 3).
  - A failed check performs no access.
- Column = sd_addr[COL_BITS-1:0]. sd_addr[10]=1 closes the bank after the access (auto-precharge).
- WRITE: in the same cycle, writes each byte of sd_data_in whose sd_dqm bit is 0.
- READ issued at edge N:
  - Reads the word and latches ~sd_dqm as the byte enables.
  - Pushes it into a CL-deep shift pipeline.
  - sd_data_out/sd_data_oe present the word from edge N+CL-1 until edge N+CL; the host samples it at edge N+CL.
  - Reads on consecutive cycles produce data on consecutive cycles; otherwise oe=0.
- PRECHARGE 0010: sd_addr[10]=1 closes all banks, else closes bank ba. Precharging a closed bank is legal.
- AUTO_REFRESH 0001:
  - All banks must be closed, else error 5 and no refresh.
  - When accepted, increments refresh_count and loads the tRFC counter = TRFC_CYC.
  - Any non-NOP/INHIBIT command while tRFC>0 raises error 6 and is ignored.
- LOAD_MODE 0000:
  - All banks must be closed, else error 5.
  - sd_addr[6:4] must be 2 or 3 and sd_addr[2:0] must be 000, else error 7 with mode unchanged.
  - When accepted, sets CL and mode_loaded=1; takes effect for the next READ.
- A WRITE at an edge where the read pipeline will drive the bus in the following cycle raises error 8. The write is still performed and that read output is suppressed (oe=0).
- Errors: err is set on the first error and err_code holds that first code until reset. Later errors are ignored.
- sd_cke=0: commands are ignored; counters, pipeline and outputs hold.

Test Plan:
- Reset, LOAD_MODE addr=0x220 (CL=2, BL=1, write-burst off), ACTIVE ba=1 row=0x155, WRITE col=0x12 data=0xDEADBEEF dqm=0, READ col=0x12 at edge N -> oe=0xF and data 0xDEADBEEF sampled at edge N+2; err=0.
- CL=3 mode (addr=0x230), WRITE with dqm=4'b0011 data 0x11223344 over 0xAAAAAAAA, READ at edge N with dqm=0 -> 0x1122AAAA sampled at N+3.
- READ with dqm=4'b1100 -> oe=4'b0011 in the data cycle; back-to-back READs to cols 0 and 1 -> two consecutive data cycles in order.
- READ to a closed bank -> err=1, err_code=2, oe stays 0. Reset, then ACTIVE followed by READ with TRCD_CYC=2 on the next edge -> err_code=3.
- AUTO_REFRESH with a bank open -> err_code=5, refresh_count=0. With all banks closed, 3 refreshes -> refresh_count=3. ACTIVE immediately after a refresh with TRFC_CYC=2 -> err_code=6.
- READ issued, then WRITE at edge N+CL-2 -> err_code=8 and that read's oe suppressed. Reset asserted during a pending read -> oe=0 next cycle and mode_loaded=0.
